// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions for the change payout stage: FSM state encoding,
// coin values, drop-bar LED patterns and a small saturating-count helper.
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int COIN_10 = 10;
  localparam int COIN_5  = 5;

  localparam int DROP_W = 10;
  localparam logic [DROP_W-1:0] DROP_10   = 10'b1111111111;
  localparam logic [DROP_W-1:0] DROP_5    = 10'b1111100000;
  localparam logic [DROP_W-1:0] DROP_NONE = 10'b0000000000;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/change_dispenser_pace_timer.sv
// Modulo-PACE_TICKS counter: tc flags the last count of an interval, half flags
// the count just before the counter reaches PACE_TICKS/2.
module change_dispenser_pace_timer #(
  parameter int PACE_TICKS = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic half
);

  localparam int CW = (PACE_TICKS > 2) ? $clog2(PACE_TICKS) : 1;
  localparam logic [CW-1:0] TC_VAL   = CW'(PACE_TICKS - 1);
  localparam logic [CW-1:0] HALF_VAL = CW'(PACE_TICKS / 2 - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc   = (cnt_q == TC_VAL);
  assign half = (cnt_q == HALF_VAL);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: pays the accepted balance as 10-coins then 5-coins, one per
// pace interval. Define CHANGE_DISPENSER_BLANK_EN to blank the drop bar mid-interval.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int BAL_W      = 8,
  parameter int PACE_TICKS = 1024,
  parameter int MAX_BAL    = 95
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BAL_W-1:0]  amount,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_money,
  output logic [BAL_W-1:0]  remaining,
  output logic [3:0]        coin_cnt
);

`ifdef CHANGE_DISPENSER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [BAL_W-1:0] MAX_BAL_V = BAL_W'(MAX_BAL);
  localparam logic [BAL_W-1:0] C10_V     = BAL_W'(COIN_10);
  localparam logic [BAL_W-1:0] C5_V      = BAL_W'(COIN_5);

  state_e              state_q, state_d;
  logic [BAL_W-1:0]    remaining_q, remaining_d;
  logic [3:0]          coin_cnt_q, coin_cnt_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tc;
  logic                half;
  logic [BAL_W-1:0]    amount_sat;

  // The counter sits at zero outside PACE so the first interval starts clean.
  change_dispenser_pace_timer #(
    .PACE_TICKS (PACE_TICKS)
  ) u_pace_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_PACE),
    .en   (state_q == ST_PACE),
    .tc   (tc),
    .half (half)
  );

  assign amount_sat = (amount > MAX_BAL_V) ? MAX_BAL_V : amount;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_cnt_d  = coin_cnt_q;
    drop_d      = drop_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        drop_d = DROP_NONE;
        if (start) begin
          remaining_d = amount_sat;
          coin_cnt_d  = 4'd0;
          busy_d      = 1'b1;
          state_d     = ST_PACE;
        end
      end
      ST_PACE: begin
        busy_d = 1'b1;
        if (tc) begin
          if (remaining_q >= C10_V) begin
            remaining_d = remaining_q - C10_V;
            drop_d      = DROP_10;
            coin_cnt_d  = sat_inc4(coin_cnt_q);
          end else if (remaining_q >= C5_V) begin
            remaining_d = remaining_q - C5_V;
            drop_d      = DROP_5;
            coin_cnt_d  = sat_inc4(coin_cnt_q);
          end else begin
            drop_d  = DROP_NONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (BLANK_EN && half) begin
          drop_d = DROP_NONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        drop_d  = DROP_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_cnt_q  <= '0;
      drop_q      <= DROP_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_cnt_q  <= coin_cnt_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign drop_money = drop_q;
  assign remaining  = remaining_q;
  assign coin_cnt   = coin_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser (PACE_TICKS=4): expected coin, blank-point
// and done events are queued at each accepted start and checked as cycles elapse.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int P = 4;

`ifdef CHANGE_DISPENSER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  amount;
  logic        busy;
  logic        done;
  logic [9:0]  drop_money;
  logic [7:0]  remaining;
  logic [3:0]  coin_cnt;

  typedef struct {
    int         at;
    logic [9:0] drop;
    logic       busy;
    logic       done;
    logic [7:0] rem;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_miss;

  change_dispenser #(
    .BAL_W      (8),
    .PACE_TICKS (P),
    .MAX_BAL    (95)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .amount     (amount),
    .busy       (busy),
    .done       (done),
    .drop_money (drop_money),
    .remaining  (remaining),
    .coin_cnt   (coin_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_drop"}, 32'(drop_money), 32'd0);
    check({tag, "_rem"},  32'(remaining), 32'd0);
    check({tag, "_cnt"},  32'(coin_cnt), 32'd0);
  endtask

  task automatic push(input int at, input logic [9:0] drop, input logic b, input logic d,
                      input int rem, input int cnt);
    exp_t e;
    e.at = at; e.drop = drop; e.busy = b; e.done = d;
    e.rem = 8'(rem); e.cnt = 4'(cnt);
    sb.push_back(e);
  endtask

  // Reference payout: greedy 10s then 5s from the clamped amount, one event per interval.
  task automatic model_payout(input int amt, input int e0);
    int a;
    int n;
    int k;
    int at;
    a = (amt > 95) ? 95 : amt;
    n = 0;
    k = 1;
    while (1) begin
      at = e0 + k * P;
      if (a >= 10) begin
        a -= 10;
        n = (n < 15) ? n + 1 : 15;
        push(at, DROP_10, 1'b1, 1'b0, a, n);
        push(at + P / 2, BLANK ? DROP_NONE : DROP_10, 1'b1, 1'b0, a, n);
      end else if (a >= 5) begin
        a -= 5;
        n = (n < 15) ? n + 1 : 15;
        push(at, DROP_5, 1'b1, 1'b0, a, n);
        push(at + P / 2, BLANK ? DROP_NONE : DROP_5, 1'b1, 1'b0, a, n);
      end else begin
        push(at, DROP_NONE, 1'b0, 1'b1, a, n);
        push(at + 1, DROP_NONE, 1'b0, 1'b0, a, n);
        break;
      end
      k++;
    end
  endtask

  task automatic tick();
    bit   covered;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    covered = 1'b0;
    while (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      check($sformatf("drop@%0d", cyc), 32'(drop_money), 32'(e.drop));
      check($sformatf("busy@%0d", cyc), 32'(busy), 32'(e.busy));
      check($sformatf("done@%0d", cyc), 32'(done), 32'(e.done));
      check($sformatf("rem@%0d", cyc), 32'(remaining), 32'(e.rem));
      check($sformatf("cnt@%0d", cyc), 32'(coin_cnt), 32'(e.cnt));
      covered = 1'b1;
    end
    if (!covered) check($sformatf("done_quiet@%0d", cyc), 32'(done), 32'd0);
  endtask

  task automatic do_start(input int amt);
    amount = 8'(amt);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check($sformatf("busy_accept@%0d", cyc), 32'(busy), 32'd1);
    model_payout(amt, cyc);
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    amount = '0;
    cyc    = 0;
    n_vec  = 0;
    n_miss = 0;

    #12;
    check_zero("por");
    rst = 1'b1;
    tick();

    // 25 with a second start at E0+5 that must be ignored
    do_start(25);
    repeat (4) tick();
    amount = 8'd50;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    amount = '0;
    drain();

    do_start(0);
    drain();

    do_start(23);
    drain();

    do_start(200);
    drain();

    // asynchronous reset in the middle of a payout, then a fresh payout
    do_start(25);
    repeat (6) tick();
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    sb.delete();
    tick();
    check_zero("rst_hold");
    #3 rst = 1'b1;
    tick();
    do_start(10);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream payout stage for the vending controller. On a start request it accepts the customer's balance and pays it out one coin at a time: 10-unit coins first, then 5-unit coins. Each coin is shown on the 10-LED drop bar, and coins are spaced by a programmable pacing interval. It replaces the inline Change state: the controller hands over the balance with a start/busy/done handshake and resumes deposit once done pulses.

## Interface
- BAL_W, 8, width of amount and remaining balance
- PACE_TICKS, 1024, clk cycles between successive coin events (≥2)
- MAX_BAL, 95, saturation ceiling applied to the accepted amount
- clk  in  1  single clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  payout request, single-cycle pulse, sampled only in IDLE
- amount  in  BAL_W  balance to pay out, sampled on the accepting edge
- busy  out  1  high from the accepting edge until payout ends
- done  out  1  single-cycle pulse when payout ends
- drop_money  out  10  LED pattern: 10'b1111111111 = 10-coin, 10'b1111100000 = 5-coin, 0 = none
- remaining  out  BAL_W  balance not yet paid; after done it holds the residual (<5)
- coin_cnt  out  4  coins paid in the current/last payout

## Operation
- States: IDLE, PACE, DONE.
- IDLE: busy=0, done=0, drop_money=0.
  - On start=1: remaining←min(amount, MAX_BAL), pace counter←0, coin_cnt←0, go to PACE.
- PACE: busy=1.
  - The pace counter increments from 0 to PACE_TICKS-1.
  - At the terminal count the counter wraps to 0, then one decision is made:
    - remaining≥10 → remaining−=10, drop_money=all ones, coin_cnt++ (saturating at 15), stay in PACE.
    - else remaining≥5 → remaining−=5, drop_money=10'b1111100000, coin_cnt++, stay in PACE.
    - else → drop_money=0, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE. remaining and coin_cnt hold until the next accepted start.
- start is ignored while in PACE or DONE; there is no queueing.
- The amount is not required to be a multiple of 5. The residual (amount mod 5) is never paid and is left on remaining.
- amount=0 is valid: no coin is paid, and done fires after one pace interval.
- Arithmetic is unsigned BAL_W. Subtraction cannot underflow because each decrement is guarded by its comparison.
- Reset (asynchronous, at any time, including mid-payout) puts the block in IDLE with all outputs 0 (busy, done, drop_money, remaining, coin_cnt) and the pace counter at 0.

## Timing
- Accepting edge is E0. Coin k (k=1..n) appears on drop_money at edge E0+k·PACE_TICKS.
- The decision at edge E0+(n+1)·PACE_TICKS moves the block to DONE. done is high in the following cycle, and busy falls on that same edge.
- Total latency from start to done is (n+1)·PACE_TICKS+1 edges, where n = floor(min(amount,MAX_BAL)/10) + (remainder≥5).
- drop_money holds its coin pattern until the next decision edge (or until the blank point, see below).
- The earliest accepted start after done is the cycle after done.

## Configuration
- CHANGE_DISPENSER_BLANK_EN defined:
  - drop_money returns to 0 when the pace counter reaches PACE_TICKS/2 after each coin.
  - Consecutive identical coins are therefore visibly separated.
- Undefined: drop_money holds each coin pattern for the full interval. This matches the legacy payout appearance.
- Ports, latency and the done timing are identical in both builds.

## Structure
- Shared vending package holds:
  - state encoding constants (IDLE, PACE, DONE)
  - coin values COIN_10=10 and COIN_5=5
  - LED patterns DROP_10=10'b1111111111, DROP_5=10'b1111100000, DROP_NONE=0
- One natural sub-module is pace_timer: a PACE_TICKS modulo counter with clear input, terminal-count output and half-count output.
- Everything else is a single FSM with registered outputs.

## Test plan
Unless stated otherwise, PACE_TICKS=4 and CHANGE_DISPENSER_BLANK_EN is undefined.
- amount=25 → drop_money = all-ones at E0+4, all-ones at E0+8, 10'b1111100000 at E0+12, 0 at E0+16. done is pulsed in the next cycle with remaining=0 and coin_cnt=3.
- amount=0 → no coin; done pulses the cycle after E0+4; coin_cnt=0.
- amount=23 → two 10-coins at E0+4 and E0+8. done follows E0+12 with remaining=3 and coin_cnt=2.
- amount=200 → saturates to 95: nine 10-coins then one 5-coin. done follows E0+44 with remaining=0 and coin_cnt=10.
- start pulsed again at E0+5 with amount=50 → ignored; the original 25 payout completes unchanged.
- rst low at E0+6 during a 25 payout → all outputs 0 immediately (asynchronously). After release, start with amount=10 → one 10-coin at the new E0+4 and done as normal.
- With CHANGE_DISPENSER_BLANK_EN defined and amount=20 → drop_money is all-ones from E0+4 and goes to 0 at E0+6. The same repeats from E0+8. done timing is unchanged.
